// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, word-addressed unified memory between the
// instruction-fetch requester (IF) and the data load/store requester (D).
// Every cycle it picks at most one requester, drives the memory port from it,
// and returns the one-cycle-latency read data to whoever issued the access.
//
// Arbitration: D wins by default. IF wins if it is the only requester, or if it
// has been denied STARVE_MAX cycles in a row. Grants may issue back-to-back
// every cycle, whether or not earlier responses are still in flight.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high reset
//   if_req     fetch request, held with if_addr stable until if_gnt
//   if_addr    fetch byte address
//   if_gnt     fetch accepted this cycle
//   if_rvalid  fetch data valid (cycle after if_gnt)
//   if_rdata   fetch data, 0 when if_rvalid is low
//   d_req      data request, held with d_we/d_addr/d_wdata stable until d_gnt
//   d_we       1 = store, 0 = load
//   d_addr     data byte address
//   d_wdata    store data
//   d_gnt      data access accepted this cycle
//   d_rvalid   data access complete (cycle after d_gnt), loads and stores
//   d_rdata    load data, 0 for store completions and when d_rvalid is low
//   mem_en     memory access strobe
//   mem_we     memory write enable
//   mem_addr   memory word address (byte address bits [MEM_AW+1:2])
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid one cycle after a read strobe
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

  grant_e            grant;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_nxt;
  logic              resp_if;
  logic              resp_d;
  logic              resp_d_load;   // the D access being completed was a load

  // Byte offset and address bits above the memory size are dropped on purpose:
  // addresses wrap modulo the memory depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                              d_addr[ADDR_W-1:MEM_AW+2],  d_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Grant decision: purely combinational from requests and registered state.
  // Reset masks every grant so nothing touches memory while reset is high.
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default on its first
  // line; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (if_req && (!d_req || (starve_cnt == STARVE_LIM))) begin
        grant = GNT_IF;
      end else if (d_req) begin
        grant = GNT_D;
      end
    end
  end

  assign if_gnt = (grant == GNT_IF);
  assign d_gnt  = (grant == GNT_D);

  // ---------------------------------------------------------------------------
  // Memory port mux: follows the grant, all zeros when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr[MEM_AW+1:2];
      end
      GNT_D: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr[MEM_AW+1:2];
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles IF asked and lost. Dropping
  // the request or winning restarts the count; it parks at the limit, where
  // the grant logic hands IF the port.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!if_req || if_gnt) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Response flags capture this cycle's grant so the data
  // coming back next cycle is steered to the requester that issued it. A grant
  // made just before reset is already in these flags, so its rvalid still
  // shows while reset is high; the reset edge then clears them.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt  <= '0;
      resp_if     <= 1'b0;
      resp_d      <= 1'b0;
      resp_d_load <= 1'b0;
    end else begin
      starve_cnt  <= starve_cnt_nxt;
      resp_if     <= if_gnt;
      resp_d      <= d_gnt;
      resp_d_load <= d_gnt & ~d_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing. Data is forced to zero unless it belongs to the
  // requester, so a store completion returns 0 on d_rdata.
  // ---------------------------------------------------------------------------
  assign if_rvalid = resp_if;
  assign d_rvalid  = resp_d;
  assign if_rdata  = resp_if ? mem_rdata : '0;
  assign d_rdata   = (resp_d && resp_d_load) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A behavioural single-port memory sits
// on the mem_* port. Each step drives one cycle of requests, checks grants and
// the memory port against the intended outcome, and pushes the expected
// response into a per-requester queue; the following step pops and compares
// against rvalid/rdata. Expected read data comes from a shadow copy of memory
// the bench maintains itself.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              mem_clear;
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  logic [DATA_W-1:0] if_q [$];
  logic [DATA_W-1:0] d_q  [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) << 16) ^ 32'(i);
  endfunction

  function automatic logic [MEM_AW-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[MEM_AW+1:2];
  endfunction

  // Behavioural memory: one-cycle read latency; junk on the data bus when no
  // read was issued so ungated routing shows up.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      mem_rdata <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= 32'hDEAD_BEEF;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
    end else begin
      mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check responses due now, check grant/port, then
  // record the responses this cycle's grant should produce next cycle.
  task automatic step(input string tag, input logic rst,
                      input logic ir, input logic [ADDR_W-1:0] ia,
                      input logic dr, input logic dw,
                      input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd,
                      input logic exp_i, input logic exp_d);
    logic              exp_v;
    logic [DATA_W-1:0] exp_data;
    logic [MEM_AW-1:0] exp_addr;
    @(negedge clk);
    reset   = rst;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    #1;
    exp_v    = (if_q.size() != 0);
    exp_data = exp_v ? if_q.pop_front() : '0;
    check({tag, " if_rvalid"}, 32'(if_rvalid), 32'(exp_v));
    check({tag, " if_rdata"}, if_rdata, exp_data);
    exp_v    = (d_q.size() != 0);
    exp_data = exp_v ? d_q.pop_front() : '0;
    check({tag, " d_rvalid"}, 32'(d_rvalid), 32'(exp_v));
    check({tag, " d_rdata"}, d_rdata, exp_data);

    exp_addr = exp_i ? widx(ia) : (exp_d ? widx(da) : '0);
    check({tag, " if_gnt"}, 32'(if_gnt), 32'(exp_i));
    check({tag, " d_gnt"}, 32'(d_gnt), 32'(exp_d));
    check({tag, " mem_en"}, 32'(mem_en), 32'(exp_i | exp_d));
    check({tag, " mem_we"}, 32'(mem_we), 32'(exp_d & dw));
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    check({tag, " mem_wdata"}, mem_wdata, exp_d ? dwd : '0);

    if (exp_i) if_q.push_back(ref_mem[widx(ia)]);
    if (exp_d) begin
      if (dw) begin
        ref_mem[widx(da)] = dwd;
        d_q.push_back('0);
      end else begin
        d_q.push_back(ref_mem[widx(da)]);
      end
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Both requesters asking: IF fetches, D loads.
  task automatic both(input string tag, input logic exp_i);
    step(tag, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_2004, '0,
         exp_i, !exp_i);
  endtask

  initial begin
    reset     = 1'b1;
    mem_clear = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset with requests held: nothing granted, no responses.
    step("rst0", 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h2000, '0, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h2000, '0, 1'b0, 1'b0);
    mem_clear = 1'b0;

    // Lone IF read of word 2.
    step("if_lone", 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle("if_lone_resp");

    // Store 0x30 to word 2048, load it back next cycle.
    step("d_st", 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h2000, 32'h30, 1'b0, 1'b1);
    step("d_ld", 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h2000, '0, 1'b0, 1'b1);
    idle("d_ld_resp");

    // Contention: D four times, IF forced on the fifth, then the count restarts.
    both("starve0", 1'b0);
    both("starve1", 1'b0);
    both("starve2", 1'b0);
    both("starve3", 1'b0);
    both("starve4", 1'b1);
    both("starve5", 1'b0);
    both("starve6", 1'b0);
    both("starve7", 1'b0);
    both("starve8", 1'b0);
    both("starve9", 1'b1);
    idle("starve_drain");

    // Dropping if_req clears a partial count.
    both("drop0", 1'b0);
    both("drop1", 1'b0);
    step("drop_gap", 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h2004, '0, 1'b0, 1'b1);
    both("drop2", 1'b0);
    both("drop3", 1'b0);
    both("drop4", 1'b0);
    both("drop5", 1'b0);
    both("drop6", 1'b1);
    idle("drop_drain");

    // Back-to-back: D load, then IF fetch; each response routed to its owner.
    step("b2b_d", 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h2008, '0, 1'b0, 1'b1);
    step("b2b_if", 1'b0, 1'b1, 32'hC, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle("b2b_if_resp");

    // Reset mid-stream with a partial starve count; rvalid of the last grant
    // still appears during reset, and the count restarts from zero after.
    both("mid0", 1'b0);
    both("mid1", 1'b0);
    both("mid2", 1'b0);
    step("mid_rst", 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h2004, '0,
         1'b0, 1'b0);
    both("post0", 1'b0);
    both("post1", 1'b0);
    both("post2", 1'b0);
    both("post3", 1'b0);
    both("post4", 1'b1);
    idle("post_drain");

    // Wrap and alignment: low bits and bits above the memory are ignored.
    step("wrap_ld", 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0000_4003, '0, 1'b0, 1'b1);
    step("wrap_st", 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h0000_4007, 32'h55,
         1'b0, 1'b1);
    step("wrap_if1", 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    step("wrap_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle("wrap_drain");
    idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port, word-addressed unified memory (.text at word 0, .data at word 2048) between two requesters: instruction fetch (IF) and data load/store (D).
- Arbitrates every cycle and drives the memory port.
- Routes the one-cycle-latency read data back to whichever requester issued the access.
- Sits between the CPU datapath and the memory array; required when the CPU moves to a multicycle/pipelined core.

Parameters:
- ADDR_W, 32, byte-address width from requesters
- DATA_W, 32, data word width
- MEM_AW, 12, memory word-address width (4096 words)
- STARVE_MAX, 4, consecutive denied IF cycles before IF is forced to win

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  data access complete (cycle after d_gnt)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  MEM_AW  memory word address = addr[MEM_AW+1:2]
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Grant decision is combinational from the current requests and registered state. At most one grant per cycle.
- mem_en equals the grant OR. The memory port mux selects the granted requester.
- mem_we = d_we on a D grant, 0 on an IF grant. All mem_* outputs are 0 when no grant.
- Priority:
  - D wins by default.
  - IF wins when if_req=1 and starve_cnt == STARVE_MAX, even if d_req=1.
  - A lone requester always wins.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments when if_req=1 and the IF grant is denied; saturates at STARVE_MAX.
  - Clears to 0 when if_gnt=1 or if_req=0.
- Pipelined, full throughput: a new grant is allowed every cycle, back-to-back, independent of outstanding responses.
- Response tracking uses registered flags resp_if and resp_d, each set to the previous cycle's grant.
  - if_rvalid = resp_if.
  - d_rvalid = resp_d, asserted for both loads and stores.
  - if_rdata = mem_rdata when resp_if, else 0.
  - d_rdata = mem_rdata when resp_d and the registered op was a load, else 0. A store completion returns 0.
- Address low bits addr[1:0] are ignored. Upper bits above MEM_AW+1 are ignored, so the address wraps modulo 4096 words.
- Latency: request presented in cycle N with grant → mem_en in N → rvalid/rdata in N+1.
- Reset (sync):
  - While reset=1, all grants, mem_en and mem_we are forced to 0.
  - resp_if, resp_d and starve_cnt clear at the edge.
  - if_rvalid and d_rvalid are 0 in the cycle after reset.
  - A grant issued in the cycle before reset asserts still produces its rvalid, because it was registered before reset. Reset asserted in the grant's response cycle suppresses nothing already registered; the next cycle is clean.
- Requests arriving in the same cycle reset deasserts are arbitrated normally.

Test Plan:
- Lone IF read: if_req=1, if_addr=0x8 → if_gnt=1 and mem_addr=2 the same cycle; next cycle if_rvalid=1 and if_rdata equals mem[2]; D outputs stay 0.
- D store then load: store d_addr=0x2000, d_wdata=0x30; next cycle load 0x2000 → mem_addr=2048 with mem_we=1 then 0; d_rvalid on both completions; load returns d_rdata=0x30; store completion returns d_rdata=0.
- Contention and starvation: if_req and d_req both held high for 6 cycles → d_gnt in cycles 0–3, if_gnt in cycle 4 (starve_cnt=4), d_gnt in cycle 5; starve_cnt returns to 0 after the IF grant.
- Back-to-back routing: D load in cycle N, IF fetch in N+1 → d_rvalid only in N+1 and if_rvalid only in N+2; each rdata matches its own address.
- Reset mid-stream: grant in cycle N, reset=1 in N+1 with both req high → no grants and mem_en=0 in N+1; rvalid for the N grant still appears in N+1; starve_cnt=0 after reset.
- Wrap and alignment: d_addr=0x4003 → mem_addr=0 (low 2 bits and bit 14 ignored).
